// File: rtl/pipeline_stall_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and helpers for the pipeline stall/flush sequencer.
//   state_e  : sequencer FSM states (RUN, STALL, MD_WAIT); encodings are visible on
//              the debug state output.
//   need_e   : number of stall cycles a hazard requires before ID may advance.
//   regMatch : true when a producer register feeds the ID instruction's sources.
package pipe_ctrl_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_STALL   = 2'd1,
    ST_MD_WAIT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    NEED_NONE = 2'd0,
    NEED_ONE  = 2'd1,
    NEED_TWO  = 2'd2
  } need_e;

  // Register 0 is hardwired to zero, so a write to it never creates a dependency.
  // rt only counts when the ID instruction actually reads it.
  function automatic logic regMatch(input logic [REG_W-1:0] r,
                                    input logic [REG_W-1:0] rs,
                                    input logic [REG_W-1:0] rt,
                                    input logic             usesRt);
    return (r != '0) && ((r == rs) || (usesRt && (r == rt)));
  endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// pipeline_stall_ctrl_if: bundle between the ID stage datapath and the stall sequencer.
//   Pipeline -> controller : id_rs, id_rt, id_uses_rt, id_is_branch, id_is_muldiv,
//                            branch_taken, ex_memread, ex_regwrite, ex_dst,
//                            mem_memread, mem_dst, md_done
//   Controller -> pipeline : pc_we, ifid_we, idex_bubble, ifid_flush, md_start,
//                            md_timeout, state, stall_cycles, md_cycles
//   master modport: pipeline side; slave modport: stall controller.
interface pipeline_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  import pipe_ctrl_pkg::*;

  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rt;
  logic             id_is_branch;
  logic             id_is_muldiv;
  logic             branch_taken;
  logic             ex_memread;
  logic             ex_regwrite;
  logic [REG_W-1:0] ex_dst;
  logic             mem_memread;
  logic [REG_W-1:0] mem_dst;
  logic             md_done;

  logic             pc_we;
  logic             ifid_we;
  logic             idex_bubble;
  logic             ifid_flush;
  logic             md_start;
  logic             md_timeout;
  state_e           state;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] md_cycles;

  modport master (
    output id_rs, id_rt, id_uses_rt, id_is_branch, id_is_muldiv, branch_taken,
           ex_memread, ex_regwrite, ex_dst, mem_memread, mem_dst, md_done,
    input  pc_we, ifid_we, idex_bubble, ifid_flush, md_start, md_timeout,
           state, stall_cycles, md_cycles
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_is_branch, id_is_muldiv, branch_taken,
           ex_memread, ex_regwrite, ex_dst, mem_memread, mem_dst, md_done,
    output pc_we, ifid_we, idex_bubble, ifid_flush, md_start, md_timeout,
           state, stall_cycles, md_cycles
  );

endinterface

// File: rtl/pipeline_stall_ctrl_hazard_need.sv
// hazard_need: purely combinational classification of ID-stage hazards that the
// forwarding network cannot hide.
//   i_idRs, i_idRt, i_idUsesRt : ID source registers and whether rt is read
//   i_idIsBranch               : ID holds a branch resolved in ID
//   i_exMemread, i_exDst       : load in EX and its destination
//   i_memMemread, i_memDst     : load in MEM and its destination
//   o_need                     : stall cycles required (NEED_NONE/ONE/TWO)
module hazard_need
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] i_idRs,
  input  logic [REG_W-1:0] i_idRt,
  input  logic             i_idUsesRt,
  input  logic             i_idIsBranch,
  input  logic             i_exMemread,
  input  logic [REG_W-1:0] i_exDst,
  input  logic             i_memMemread,
  input  logic [REG_W-1:0] i_memDst,
  output need_e            o_need
);

  logic w_exMatch;
  logic w_memMatch;

  assign w_exMatch  = regMatch(i_exDst,  i_idRs, i_idRt, i_idUsesRt);
  assign w_memMatch = regMatch(i_memDst, i_idRs, i_idRt, i_idUsesRt);

  // A branch compares in ID, so it needs load data one stage earlier than an ALU
  // op: a load in EX costs it two bubbles, a load in MEM one. ALU results from EX
  // are forwarded to the branch comparator and never stall.
  always_comb begin
    o_need = NEED_NONE;
    if (i_idIsBranch && i_exMemread && w_exMatch) begin
      o_need = NEED_TWO;
    end else if ((i_exMemread && w_exMatch) ||
                 (i_idIsBranch && i_memMemread && w_memMatch)) begin
      o_need = NEED_ONE;
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: stall/flush sequencer for the 5-stage pipeline, next to the
// ID-stage forwarding logic. Stalls on load-use and branch-on-load hazards, runs the
// multi-cycle mul/div start/done handshake with a timeout, and drives the PC and
// IF-ID write enables, the ID-EX bubble and the IF-ID flush.
//   clk, reset : pipeline clock, asynchronous active-high reset
//   bus        : pipeline_stall_ctrl_if slave modport (hazard inputs, control outputs,
//                debug state and statistics)
// Parameters: MD_TIMEOUT (max MD_WAIT cycles before forced release), CNT_W (stat width).
// Build option: define STALL_STATS_EN to enable the saturating stall_cycles and
// md_cycles counters; otherwise both outputs are tied to zero.
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input logic                  clk,
  input logic                  reset,
  pipeline_stall_ctrl_if.slave bus
);

  localparam int MD_CNT_W = $clog2(MD_TIMEOUT + 1);

  state_e              r_state;
  state_e              w_nextState;
  logic [MD_CNT_W-1:0] r_mdCnt;
  logic                r_mdTimeout;
  need_e               w_need;
  logic                w_stall;
  logic                w_mdStart;
  logic                w_flush;
  logic                w_mdExpire;
  logic                w_mdLast;
  logic                w_unusedRegwrite;

  // EX ALU results reach ID through forwarding, so ex_regwrite never causes a stall.
  assign w_unusedRegwrite = bus.ex_regwrite;

  hazard_need u_hazardNeed (
    .i_idRs       (bus.id_rs),
    .i_idRt       (bus.id_rt),
    .i_idUsesRt   (bus.id_uses_rt),
    .i_idIsBranch (bus.id_is_branch),
    .i_exMemread  (bus.ex_memread),
    .i_exDst      (bus.ex_dst),
    .i_memMemread (bus.mem_memread),
    .i_memDst     (bus.mem_dst),
    .o_need       (w_need)
  );

  assign w_mdLast = (r_mdCnt == MD_CNT_W'(MD_TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_nextState;
    end
  end

  // A single-bubble hazard stays in RUN and re-evaluates next cycle; only the
  // two-bubble branch-on-load case needs the extra STALL state.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_need == NEED_TWO) begin
          w_nextState = ST_STALL;
        end else if ((w_need == NEED_NONE) && bus.id_is_muldiv) begin
          w_nextState = ST_MD_WAIT;
        end
      end
      ST_STALL: w_nextState = ST_RUN;
      ST_MD_WAIT: begin
        if (bus.md_done || w_mdLast) begin
          w_nextState = ST_RUN;
        end
      end
      default: w_nextState = ST_RUN;
    endcase
  end

  // Mealy outputs in RUN so a hazard stalls in the same cycle it is seen.
  // Hazard stalls take priority over launching a mul/div.
  always_comb begin
    w_stall    = 1'b0;
    w_mdStart  = 1'b0;
    w_flush    = 1'b0;
    w_mdExpire = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_need != NEED_NONE) begin
          w_stall = 1'b1;
        end else if (bus.id_is_muldiv) begin
          w_mdStart = 1'b1;
          w_stall   = 1'b1;
        end else begin
          w_flush = bus.branch_taken;
        end
      end
      ST_STALL: w_stall = 1'b1;
      ST_MD_WAIT: begin
        if (!bus.md_done) begin
          if (w_mdLast) begin
            w_mdExpire = 1'b1;
          end else begin
            w_stall = 1'b1;
          end
        end
      end
      default: w_stall = 1'b0;
    endcase
  end

  // The wait counter restarts whenever MD_WAIT is not continuing, so it is zero on
  // entry without a separate clear path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mdCnt     <= '0;
      r_mdTimeout <= 1'b0;
    end else begin
      if ((r_state == ST_MD_WAIT) && w_stall) begin
        r_mdCnt <= r_mdCnt + MD_CNT_W'(1);
      end else begin
        r_mdCnt <= '0;
      end
      if (w_mdExpire) begin
        r_mdTimeout <= 1'b1;
      end
    end
  end

`ifdef STALL_STATS_EN
  logic [CNT_W-1:0] r_stallCycles;
  logic [CNT_W-1:0] r_mdCycles;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stallCycles <= '0;
      r_mdCycles    <= '0;
    end else begin
      if (w_stall && (r_stallCycles != {CNT_W{1'b1}})) begin
        r_stallCycles <= r_stallCycles + CNT_W'(1);
      end
      if ((r_state == ST_MD_WAIT) && (r_mdCycles != {CNT_W{1'b1}})) begin
        r_mdCycles <= r_mdCycles + CNT_W'(1);
      end
    end
  end

  assign bus.stall_cycles = r_stallCycles;
  assign bus.md_cycles    = r_mdCycles;
`else
  assign bus.stall_cycles = {CNT_W{1'b0}};
  assign bus.md_cycles    = {CNT_W{1'b0}};
`endif

  // While reset is held the pipeline is frozen and the IF-ID slot is squashed.
  assign bus.pc_we       = !reset && !w_stall;
  assign bus.ifid_we     = !reset && !w_stall;
  assign bus.idex_bubble = reset || w_stall;
  assign bus.ifid_flush  = reset || w_flush;
  assign bus.md_start    = !reset && w_mdStart;
  assign bus.md_timeout  = r_mdTimeout;
  assign bus.state       = r_state;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: scoreboard bench for pipeline_stall_ctrl. Each stimulus
// cycle runs a behavioural model and queues the expected outputs; a monitor on the
// falling edge pops and compares. Directed scenarios first, then random traffic.
// Honours STALL_STATS_EN the same way the design does.
module tb_pipeline_stall_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int MD_TIMEOUT = 8;
  localparam int CNT_W      = 16;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  typedef struct {
    logic [4:0] idRs;
    logic [4:0] idRt;
    logic [4:0] exDst;
    logic [4:0] memDst;
    bit idUsesRt;
    bit idIsBranch;
    bit idIsMuldiv;
    bit branchTaken;
    bit exMemread;
    bit exRegwrite;
    bit memMemread;
    bit mdDone;
    bit rst;
  } stim_t;

  typedef struct {
    int seq;
    bit pcWe;
    bit ifidWe;
    bit bubble;
    bit flush;
    bit mdStart;
    bit mdTimeout;
    int state;
    int stallCycles;
    int mdCycles;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pipeline_stall_ctrl_if #(.CNT_W(CNT_W)) bus();

  pipeline_stall_ctrl #(.MD_TIMEOUT(MD_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t expQ[$];
  int total = 0;
  int bad   = 0;
  int seqNo = 0;

  // Model state: mode 0=RUN 1=STALL 2=MD_WAIT, plus cycles already waited on mul/div.
  int mState = 0;
  int mAge   = 0;
  int mStall = 0;
  int mMd    = 0;
  bit mTimeout = 1'b0;

  function automatic stim_t idle(input bit rst);
    stim_t s;
    s.idRs = 5'd0; s.idRt = 5'd0; s.exDst = 5'd0; s.memDst = 5'd0;
    s.idUsesRt = 0; s.idIsBranch = 0; s.idIsMuldiv = 0; s.branchTaken = 0;
    s.exMemread = 0; s.exRegwrite = 0; s.memMemread = 0; s.mdDone = 0;
    s.rst = rst;
    return s;
  endfunction

  function automatic stim_t randStim();
    stim_t s;
    s.idRs        = 5'($urandom_range(0, 3));
    s.idRt        = 5'($urandom_range(0, 3));
    s.exDst       = 5'($urandom_range(0, 3));
    s.memDst      = 5'($urandom_range(0, 3));
    s.idUsesRt    = ($urandom_range(0, 1) == 1);
    s.idIsBranch  = ($urandom_range(0, 3) == 0);
    s.idIsMuldiv  = ($urandom_range(0, 5) == 0);
    s.branchTaken = ($urandom_range(0, 1) == 1);
    s.exMemread   = ($urandom_range(0, 2) == 0);
    s.exRegwrite  = s.exMemread || ($urandom_range(0, 1) == 1);
    s.memMemread  = ($urandom_range(0, 2) == 0);
    s.mdDone      = ($urandom_range(0, 9) == 0);
    s.rst         = ($urandom_range(0, 299) == 0);
    return s;
  endfunction

  function automatic int calcNeed(input stim_t s);
    bit exHit, memHit;
    exHit  = (s.exDst != 0)  && ((s.exDst == s.idRs)  || (s.idUsesRt && s.exDst == s.idRt));
    memHit = (s.memDst != 0) && ((s.memDst == s.idRs) || (s.idUsesRt && s.memDst == s.idRt));
    if (s.idIsBranch && s.exMemread && exHit) return 2;
    if ((s.exMemread && exHit) || (s.idIsBranch && s.memMemread && memHit)) return 1;
    return 0;
  endfunction

  task automatic modelStep(input stim_t s, output exp_t e);
    int need;
    bit stall;
    e.seq = seqNo;
    seqNo++;
    stall = 1'b0;
    e.flush = 1'b0;
    e.mdStart = 1'b0;
    if (s.rst) begin
      mState = 0; mAge = 0; mTimeout = 1'b0; mStall = 0; mMd = 0;
      e.pcWe = 0; e.ifidWe = 0; e.bubble = 1; e.flush = 1; e.mdStart = 0;
      e.mdTimeout = 0; e.state = 0; e.stallCycles = 0; e.mdCycles = 0;
    end else begin
      e.state = mState;
      e.mdTimeout = mTimeout;
`ifdef STALL_STATS_EN
      e.stallCycles = mStall;
      e.mdCycles = mMd;
`else
      e.stallCycles = 0;
      e.mdCycles = 0;
`endif
      need = calcNeed(s);
      if (mState == 0) begin
        if (need > 0) begin
          stall = 1'b1;
          if (need == 2) mState = 1;
        end else if (s.idIsMuldiv) begin
          stall = 1'b1;
          e.mdStart = 1'b1;
          mState = 2;
          mAge = 0;
        end else begin
          e.flush = s.branchTaken;
        end
      end else if (mState == 1) begin
        stall = 1'b1;
        mState = 0;
      end else begin
        if (mMd < CNT_MAX) mMd++;
        if (s.mdDone) begin
          mState = 0;
        end else if (mAge == MD_TIMEOUT - 1) begin
          mTimeout = 1'b1;
          mState = 0;
        end else begin
          stall = 1'b1;
          mAge++;
        end
      end
      if (stall && mStall < CNT_MAX) mStall++;
      e.pcWe = !stall;
      e.ifidWe = !stall;
      e.bubble = stall;
    end
  endtask

  task automatic driveInputs(input stim_t s);
    reset            = s.rst;
    bus.id_rs        = s.idRs;
    bus.id_rt        = s.idRt;
    bus.id_uses_rt   = s.idUsesRt;
    bus.id_is_branch = s.idIsBranch;
    bus.id_is_muldiv = s.idIsMuldiv;
    bus.branch_taken = s.branchTaken;
    bus.ex_memread   = s.exMemread;
    bus.ex_regwrite  = s.exRegwrite;
    bus.ex_dst       = s.exDst;
    bus.mem_memread  = s.memMemread;
    bus.mem_dst      = s.memDst;
    bus.md_done      = s.mdDone;
  endtask

  task automatic applyStimulus(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    driveInputs(s);
    modelStep(s, e);
    expQ.push_back(e);
  endtask

  task automatic compareField(input string name, input int seq, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("[TB] FAIL %s cycle=%0d got=%0d want=%0d", name, seq, act, want);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    compareField("pc_we",        e.seq, int'(bus.pc_we),        int'(e.pcWe));
    compareField("ifid_we",      e.seq, int'(bus.ifid_we),      int'(e.ifidWe));
    compareField("idex_bubble",  e.seq, int'(bus.idex_bubble),  int'(e.bubble));
    compareField("ifid_flush",   e.seq, int'(bus.ifid_flush),   int'(e.flush));
    compareField("md_start",     e.seq, int'(bus.md_start),     int'(e.mdStart));
    compareField("md_timeout",   e.seq, int'(bus.md_timeout),   int'(e.mdTimeout));
    compareField("state",        e.seq, int'(bus.state),        e.state);
    compareField("stall_cycles", e.seq, int'(bus.stall_cycles), e.stallCycles);
    compareField("md_cycles",    e.seq, int'(bus.md_cycles),    e.mdCycles);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  initial begin : stimulus
    stim_t s;
    driveInputs(idle(1'b1));
    repeat (2) applyStimulus(idle(1'b1));
    applyStimulus(idle(1'b0));

    // Load-use on rs: one bubble, then the load has moved on.
    s = idle(0); s.exMemread = 1; s.exRegwrite = 1; s.exDst = 5'd5; s.idRs = 5'd5;
    applyStimulus(s);
    s.exMemread = 0; s.memMemread = 1; s.memDst = 5'd5; s.exDst = 5'd0;
    applyStimulus(s);

    // Branch on a load in EX via rt: two bubbles, taken ignored while stalled.
    s = idle(0); s.idIsBranch = 1; s.branchTaken = 1; s.exMemread = 1; s.exRegwrite = 1;
    s.exDst = 5'd7; s.idRt = 5'd7; s.idUsesRt = 1; s.idRs = 5'd2;
    applyStimulus(s);
    s.exMemread = 0; s.exDst = 5'd0; s.memMemread = 1; s.memDst = 5'd7;
    applyStimulus(s);
    s.memMemread = 0; s.memDst = 5'd0;
    applyStimulus(s);

    // Branch on a load in MEM: single bubble.
    s = idle(0); s.idIsBranch = 1; s.memMemread = 1; s.memDst = 5'd3; s.idRs = 5'd3;
    applyStimulus(s);

    // No hazard: load to r0, and load to rt when rt is not read.
    s = idle(0); s.exMemread = 1; s.exDst = 5'd0; s.idRs = 5'd0;
    applyStimulus(s);
    s = idle(0); s.exMemread = 1; s.exDst = 5'd9; s.idRt = 5'd9; s.idRs = 5'd1;
    applyStimulus(s);

    // Hazard wins over launching a mul/div.
    s = idle(0); s.idIsMuldiv = 1; s.exMemread = 1; s.exDst = 5'd4; s.idRs = 5'd4;
    applyStimulus(s);

    // Mul/div finishing on its own; md_done in RUN is ignored afterwards.
    s = idle(0); s.idIsMuldiv = 1;
    for (int i = 0; i < 4; i++) applyStimulus(s);
    s.mdDone = 1;
    applyStimulus(s);
    s = idle(0); s.mdDone = 1;
    applyStimulus(s);

    // Mul/div that never finishes: forced release and sticky timeout flag.
    s = idle(0); s.idIsMuldiv = 1;
    for (int i = 0; i < MD_TIMEOUT + 1; i++) applyStimulus(s);
    s = idle(0); s.mdDone = 1; s.branchTaken = 1;
    applyStimulus(s);
    repeat (2) applyStimulus(idle(0));

    // Reset in the middle of a mul/div wait.
    s = idle(0); s.idIsMuldiv = 1;
    for (int i = 0; i < 3; i++) applyStimulus(s);
    applyStimulus(idle(1));
    repeat (2) applyStimulus(idle(0));

    for (int i = 0; i < 3000; i++) applyStimulus(randStim());
    applyStimulus(idle(0));

    repeat (3) @(negedge clk);
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain pending=%0d want=0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
